clock_divider_prog: RTL and testbench
=====================================

# clock_divider_prog

Programmable integer clock divider for the fan controller's timing chain; the counterpart of the 2x clock multiplier. It derives a slow registered clock and a matching one-cycle tick from `clk_in` for the PWM and tach blocks. It accepts runtime divisor updates through a load/ack handshake and applies them only at a period boundary, so `clk_out` never glitches. Start and stop are also glitch-free.

## Interface
Parameters:
- `CNT_W`, 16: width of the divisor and the internal counter.
- `DEFAULT_DIV`, 4: active divisor after reset. Must be ≥2 and ≤2^CNT_W−1.

Ports:
- `clk_in` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run request. Level-sensitive.
- `div_val` in CNT_W: new divisor N.
- `div_load` in 1: one-cycle strobe that captures `div_val`.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse, high in the same cycle that `clk_out` rises.
- `div_ack` out 1: one-cycle pulse when a pending divisor becomes active.
- `div_err` out 1: one-cycle pulse when a load is rejected.
- `busy` out 1: high while a divisor is pending.

## Operation
- The active divisor N sets the `clk_out` period to N `clk_in` cycles.
- Phase counter `cnt` runs 0..N−1 and wraps.
- `clk_out` is high while `cnt` < N>>1 and low otherwise. Examples: N=2 gives 1 high / 1 low; N=5 gives 2 high / 3 low.
- State machine:
  - STOP: `cnt`=0, `clk_out`=0. If `en`=1, go to RUN.
  - RUN: counts. At the wrap point (`cnt`=N−1):
    - if `en`=0, go to STOP;
    - else if a divisor is pending, go to SWITCH.
  - SWITCH: lasts exactly one transition. The pending divisor is copied to active, `div_ack` pulses, `busy` clears, and the next period starts with the new N. Return to RUN.
- Load rules:
  - `div_load` with `div_val` ≥2: the value goes to the pending register and `busy` is set.
  - A second valid load while pending: the last value wins. Only one `div_ack` is issued.
  - `div_load` with `div_val` <2: rejected. `div_err` pulses the next cycle; pending and active are unchanged.
  - Loading while in STOP: the value becomes active immediately. `div_ack` pulses the next cycle and `busy` never rises.
- Stopping never truncates a period. `clk_out` always completes its low phase before holding low.

## Timing
- Reset values:
  - `clk_out`=0, `tick`=0, `div_ack`=0, `div_err`=0, `busy`=0.
  - State STOP, `cnt`=0, active N=`DEFAULT_DIV`, pending empty.
- All outputs are registered. There is no combinational path from any input to any output.
- Start: `en` sampled high in STOP at edge k. At edge k+1, state is RUN, `cnt`=0, `clk_out`=1, `tick`=1.
- Subsequent rising edges of `clk_out` occur every N cycles. `tick` is high only in cycles where `cnt`=0 in RUN.
- Divisor switch:
  - The first period with the new N begins at the edge after the wrap (`cnt`=N_old−1).
  - `div_ack`, `tick` and the `clk_out` rise occur in that same cycle.
- `div_load` in the same cycle as the wrap: the loaded value applies at this wrap.
- `div_load` in the same cycle as `en` falling at the wrap: the stop takes priority. The value stays pending and `busy` remains 1; it applies at the next start, with `div_ack` in the first RUN cycle.
- Reset mid-period: all outputs go to their reset values immediately (asynchronous). The pending value is discarded.

## Configuration
- `CLKDIV_SYNC_EN` defined:
  - Adds input port `sync_in` (1 bit), sampled through a 2-flop synchronizer followed by rising-edge detection.
  - A detected edge in RUN forces `cnt`=0, `clk_out`=1 and `tick`=1 on the following edge, restarting the phase. This takes priority over a pending switch; the switch is deferred to the next wrap.
  - `sync_in` is ignored in STOP.
- `CLKDIV_SYNC_EN` not defined: the port is absent and the phase is free-running.

## Test plan
- Reset, then `en`=1: `clk_out` has period 4 with 2 high / 2 low, and `tick` pulses every 4 cycles starting 1 cycle after `en`.
- Load 7 mid-period while N=4: `busy` stays 1 until the wrap. `div_ack` coincides with the next `tick`. The new pattern is 3 high / 4 low.
- Load 0, then load 1: `div_err` pulses each time. The period remains 4 and `busy` stays 0.
- Loads 6 and then 9 within one period: a single `div_ack`, and the active N is 9.
- `en` dropped at `cnt`=1 with N=4: the period completes and `clk_out` holds 0 from the edge after `cnt`=3. Re-raising `en` gives `tick` one cycle later.
- `rst` asserted mid-high-phase: `clk_out` is 0 immediately and N returns to 4. With `CLKDIV_SYNC_EN`, a `sync_in` edge restarts `tick` 3 cycles after the edge (2 synchronizer flops + 1 registered output).

Source files
------------

// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider with glitch-free divisor switch and start/stop.
// Optional CLKDIV_SYNC_EN adds sync_in for external phase restart.
module clock_divider_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic [CNT_W-1:0] act_n, n_act;
  logic [CNT_W-1:0] pend_n, n_pend;
  logic             pend_v, n_pv;
  logic             n_clk, n_tick, n_ack, n_err;
  logic             ld_ok, pv_eff, wrap;
  logic [CNT_W-1:0] pn_eff;
  logic             sync_edge;

`ifdef CLKDIV_SYNC_EN
  logic [2:0] sync_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], sync_in};
  end

  assign sync_edge = sync_q[1] & ~sync_q[2];
`else
  assign sync_edge = 1'b0;
`endif

  assign wrap = (cnt == act_n - CNT_W'(1));

  always_comb begin
    ld_ok   = div_load && (div_val >= CNT_W'(2));
    pv_eff  = ld_ok | pend_v;
    pn_eff  = ld_ok ? div_val : pend_n;
    n_state = state;
    n_cnt   = cnt;
    n_act   = act_n;
    n_pend  = pn_eff;
    n_pv    = pv_eff;
    n_tick  = 1'b0;
    n_ack   = 1'b0;
    n_err   = div_load && !ld_ok;
    unique case (state)
      STOP: begin
        n_cnt = '0;
        // A stopped divider has no period to protect, so loads apply at once
        if (ld_ok || (en && pend_v)) begin
          n_act = pn_eff;
          n_pv  = 1'b0;
          n_ack = 1'b1;
        end
        if (en) begin
          n_state = RUN;
          n_tick  = 1'b1;
        end
      end
      RUN, SWITCH: begin
        if (sync_edge) begin
          n_state = RUN;
          n_cnt   = '0;
          n_tick  = 1'b1;
        end else if (wrap) begin
          n_cnt = '0;
          if (!en) begin
            n_state = STOP;
          end else if (pv_eff) begin
            n_state = SWITCH;
            n_act   = pn_eff;
            n_pv    = 1'b0;
            n_ack   = 1'b1;
            n_tick  = 1'b1;
          end else begin
            n_state = RUN;
            n_tick  = 1'b1;
          end
        end else begin
          n_state = RUN;
          n_cnt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        n_state = STOP;
        n_cnt   = '0;
      end
    endcase
    n_clk = (n_state != STOP) && (n_cnt < (n_act >> 1));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= STOP;
      cnt     <= '0;
      act_n   <= CNT_W'(DEFAULT_DIV);
      pend_n  <= '0;
      pend_v  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= n_state;
      cnt     <= n_cnt;
      act_n   <= n_act;
      pend_n  <= n_pend;
      pend_v  <= n_pv;
      clk_out <= n_clk;
      tick    <= n_tick;
      div_ack <= n_ack;
      div_err <= n_err;
      busy    <= n_pv;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed testbench for clock_divider_prog.
// Outputs are sampled on the falling edge of clk_in.
module tb_clock_divider_prog;

  logic        clk_in;
  logic        rst;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
`ifdef CLKDIV_SYNC_EN
  logic        sync_in;
`endif
  logic        clk_out;
  logic        tick;
  logic        div_ack;
  logic        div_err;
  logic        busy;

  int checks;
  int errors;

  clock_divider_prog #(
    .CNT_W(16),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .div_val(div_val),
    .div_load(div_load),
`ifdef CLKDIV_SYNC_EN
    .sync_in(sync_in),
`endif
    .clk_out(clk_out),
    .tick(tick),
    .div_ack(div_ack),
    .div_err(div_err),
    .busy(busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Observed bundle: {clk_out, tick, div_ack, div_err, busy}
  function automatic logic [4:0] obs();
    return {clk_out, tick, div_ack, div_err, busy};
  endfunction

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    @(negedge clk_in);
    e = 5'b00000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset got %b want %b", obs(), e);
    end
    rst = 1'b0;
    cyc(); cyc();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL stop_idle got %b want %b", obs(), e);
    end
  endtask

  task automatic test_run();
    logic [4:0] e;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      e = {(i % 4) < 2, (i % 4) == 0, 3'b000};
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL run_n4 i=%0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_bad_loads();
    logic [4:0] e;
    logic [4:0] want [5];
    want[0] = 5'b11010; want[1] = 5'b10010; want[2] = 5'b00000;
    want[3] = 5'b00000; want[4] = 5'b11000;
    div_val = 16'd0; div_load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) div_val = 16'd1;
      if (i == 2) div_load = 1'b0;
      cyc();
      e = want[i];
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL bad_load i=%0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_load7();
    logic [4:0] e;
    cyc();
    div_val = 16'd7; div_load = 1'b1;
    cyc();
    e = 5'b00001;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL load7_pend got %b want %b", obs(), e);
    end
    div_load = 1'b0;
    cyc();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL load7_wait got %b want %b", obs(), e);
    end
    cyc();
    e = 5'b11100;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL load7_ack got %b want %b", obs(), e);
    end
    for (int i = 1; i < 7; i++) begin
      cyc();
      e = {i < 3, 4'b0000};
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL run_n7 i=%0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_last_wins();
    logic [4:0] e;
    int acks;
    acks = 0;
    cyc();
    div_val = 16'd6; div_load = 1'b1;
    cyc();
    acks += int'(div_ack);
    div_val = 16'd9;
    cyc();
    acks += int'(div_ack);
    e = 5'b10001;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lw_pend got %b want %b", obs(), e);
    end
    div_load = 1'b0;
    for (int i = 3; i < 7; i++) begin
      cyc();
      acks += int'(div_ack);
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL lw_early_ack got %0d want 0", acks);
    end
    cyc();
    e = 5'b11100;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lw_ack got %b want %b", obs(), e);
    end
    for (int i = 1; i < 9; i++) begin
      cyc();
      e = {i < 4, 4'b0000};
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL run_n9 i=%0d got %b want %b", i, obs(), e);
      end
    end
    cyc();
    e = 5'b11000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL n9_wrap got %b want %b", obs(), e);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    div_val = 16'd5; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    e = 5'b10001;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rm_pre got %b want %b", obs(), e);
    end
    #2 rst = 1'b1;
    #1;
    e = 5'b00000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rm_async got %b want %b", obs(), e);
    end
    @(negedge clk_in);
    rst = 1'b0;
    cyc();
    e = 5'b11000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rm_start got %b want %b", obs(), e);
    end
    for (int i = 1; i < 4; i++) begin
      cyc();
      e = {i < 2, 4'b0000};
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL rm_n4 i=%0d got %b want %b", i, obs(), e);
      end
    end
    cyc();
    e = 5'b11000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rm_wrap got %b want %b", obs(), e);
    end
  endtask

  task automatic test_stop();
    logic [4:0] e;
    en = 1'b0;
    for (int i = 1; i < 7; i++) begin
      cyc();
      e = {i < 2, 4'b0000};
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL stop i=%0d got %b want %b", i, obs(), e);
      end
    end
    en = 1'b1;
    cyc();
    e = 5'b11000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL restart got %b want %b", obs(), e);
    end
  endtask

  task automatic test_stop_pending();
    logic [4:0] e;
    cyc(); cyc(); cyc();
    en = 1'b0; div_val = 16'd5; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    e = 5'b00001;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL sp_stop got %b want %b", obs(), e);
    end
    cyc();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL sp_hold got %b want %b", obs(), e);
    end
    en = 1'b1;
    cyc();
    e = 5'b11100;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL sp_ack got %b want %b", obs(), e);
    end
    for (int i = 1; i < 5; i++) begin
      cyc();
      e = {i < 2, 4'b0000};
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL run_n5 i=%0d got %b want %b", i, obs(), e);
      end
    end
    cyc();
    e = 5'b11000;
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL n5_wrap got %b want %b", obs(), e);
    end
  endtask

  task automatic test_stop_load();
    logic [4:0] e;
    logic [4:0] want [7];
    want[0] = 5'b00000; want[1] = 5'b00100; want[2] = 5'b00000;
    want[3] = 5'b11000; want[4] = 5'b00000; want[5] = 5'b00000;
    want[6] = 5'b11000;
    en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin div_val = 16'd3; div_load = 1'b1; end
      if (i == 2) div_load = 1'b0;
      if (i == 3) en = 1'b1;
      cyc();
      e = want[i];
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL stop_load i=%0d got %b want %b", i, obs(), e);
      end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    logic [4:0] e;
    logic [4:0] want [7];
    want[0] = 5'b00001; want[1] = 5'b00001; want[2] = 5'b11100;
    want[3] = 5'b10000; want[4] = 5'b10000; want[5] = 5'b10000;
    want[6] = 5'b11000;
    div_val = 16'd8; div_load = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) div_load = 1'b0;
      if (i == 4) sync_in = 1'b1;
      cyc();
      e = want[i];
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL sync i=%0d got %b want %b", i, obs(), e);
      end
    end
    sync_in = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif
    test_reset();
    test_run();
    test_bad_loads();
    test_load7();
    test_last_wins();
    test_reset_mid();
    test_stop();
    test_stop_pending();
    test_stop_load();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
